// File: rtl/ecg_enc_pkg.sv
// Shared constants and state encoding for the ECG encoder output path.
package ecg_enc_pkg;

    localparam int ECG_MAX_BITS = 50;
    localparam int ECG_SIZE_W   = 7;
    localparam int PACK_ACC_W   = 128;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } pack_state_e;

endpackage

// File: rtl/ecg_msb_aligner.sv
// Masks an MSB-aligned ECG to its size and places it just below the bits
// already held in the packing accumulator.
module ecg_msb_aligner
    import ecg_enc_pkg::*;
(
    input  logic [ECG_MAX_BITS-1:0] encoded_ecg,
    input  logic [ECG_SIZE_W-1:0]   size,
    input  logic [7:0]              fill,
    output logic [PACK_ACC_W-1:0]   field
);

    logic [ECG_MAX_BITS-1:0] w_mask;
    logic [ECG_MAX_BITS-1:0] w_masked;

    // Sizes past the field width yield a full mask; the caller never writes those.
    assign w_mask   = ~({ECG_MAX_BITS{1'b1}} >> size);
    assign w_masked = encoded_ecg & w_mask;
    assign field    = {w_masked, {(PACK_ACC_W-ECG_MAX_BITS){1'b0}}} >> fill;

endmodule

// File: rtl/ecg_bitstream_packer.sv
// Packs variable-length ECGs into fixed OUT_W-bit words with flush/zero-pad.
// Define ECG_PACK_BITCNT_EN to enable the bits_total accepted-bit counter.
module ecg_bitstream_packer
    import ecg_enc_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ecg_valid,
    output logic                    ecg_ready,
    input  logic [ECG_MAX_BITS-1:0] encoded_ecg,
    input  logic [ECG_SIZE_W-1:0]   sizeof_encoded_ecg,
    input  logic                    flush,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [OUT_W-1:0]        word_out,
    output logic                    word_last,
    output logic                    flush_done,
    output logic [7:0]              fill_level,
    output logic                    size_err,
    output logic [31:0]             bits_total
);

    localparam logic [7:0] W_OUT       = 8'(OUT_W);
    localparam logic [7:0] W_OUT_MASK  = 8'(OUT_W - 1);
    localparam logic [7:0] READY_LIMIT = 8'(PACK_ACC_W - ECG_MAX_BITS);
    localparam logic [ECG_SIZE_W-1:0] MAX_SIZE = ECG_SIZE_W'(ECG_MAX_BITS);

    pack_state_e            r_state;
    logic [PACK_ACC_W-1:0]  r_acc;
    logic [7:0]             r_fill;
    logic                   r_size_err;
    logic                   r_flush_done;

    pack_state_e            w_state_next;
    logic [PACK_ACC_W-1:0]  w_acc_next;
    logic [PACK_ACC_W-1:0]  w_acc_popped;
    logic [PACK_ACC_W-1:0]  w_field;
    logic [7:0]             w_fill_next;
    logic [7:0]             w_fill_popped;
    logic                   w_done_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_legal;
    logic                   w_write;

    assign w_push  = ecg_valid && ecg_ready;
    assign w_pop   = word_valid && word_ready;
    assign w_legal = (sizeof_encoded_ecg != '0) && (sizeof_encoded_ecg <= MAX_SIZE);
    assign w_write = w_push && w_legal;

    // A same-cycle pop is applied before the push lands.
    assign w_acc_popped  = w_pop ? (r_acc << OUT_W) : r_acc;
    assign w_fill_popped = w_pop ? (r_fill - W_OUT) : r_fill;

    ecg_msb_aligner u_aligner (
        .encoded_ecg (encoded_ecg),
        .size        (sizeof_encoded_ecg),
        .fill        (w_fill_popped),
        .field       (w_field)
    );

    always_comb begin
        ecg_ready  = (r_state == RUN) && (r_fill <= READY_LIMIT);
        word_valid = 1'b0;
        word_last  = 1'b0;
        case (r_state)
            RUN:     word_valid = (r_fill >= W_OUT);
            DRAIN: begin
                word_valid = (r_fill != 8'd0);
                word_last  = (r_fill == W_OUT);
            end
            default: word_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = w_acc_popped;
        w_fill_next  = w_fill_popped;
        w_done_next  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_write) begin
                    w_acc_next  = w_acc_popped | w_field;
                    w_fill_next = w_fill_popped + {1'b0, sizeof_encoded_ecg};
                end
                // An empty accumulator has nothing to pad, so the flush completes at once.
                if (flush) begin
                    if (w_fill_next == 8'd0) w_done_next  = 1'b1;
                    else                     w_state_next = PAD;
                end
            end
            PAD: begin
                w_fill_next  = (r_fill + W_OUT_MASK) & ~W_OUT_MASK;
                w_state_next = DRAIN;
            end
            DRAIN: begin
                if (w_pop && (r_fill == W_OUT)) begin
                    w_state_next = RUN;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_acc        <= '0;
            r_fill       <= 8'd0;
            r_size_err   <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_acc        <= w_acc_next;
            r_fill       <= w_fill_next;
            r_size_err   <= r_size_err | (w_push && (sizeof_encoded_ecg > MAX_SIZE));
            r_flush_done <= w_done_next;
        end
    end

`ifdef ECG_PACK_BITCNT_EN
    logic [31:0] r_bits_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_bits_total <= 32'd0;
        else if (w_write) r_bits_total <= r_bits_total + 32'(sizeof_encoded_ecg);
    end

    assign bits_total = r_bits_total;
`else
    assign bits_total = 32'd0;
`endif

    assign word_out   = r_acc[PACK_ACC_W-1 -: OUT_W];
    assign fill_level = r_fill;
    assign size_err   = r_size_err;
    assign flush_done = r_flush_done;

endmodule

// File: tb/tb_ecg_bitstream_packer.sv
// Directed self-checking bench for ecg_bitstream_packer (OUT_W = 32).
module tb_ecg_bitstream_packer;

    logic        clk;
    logic        rst_n;
    logic        ecg_valid;
    logic        ecg_ready;
    logic [49:0] encoded_ecg;
    logic [6:0]  sizeof_encoded_ecg;
    logic        flush;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_out;
    logic        word_last;
    logic        flush_done;
    logic [7:0]  fill_level;
    logic        size_err;
    logic [31:0] bits_total;

    int nChecks   = 0;
    int nFailures = 0;

    ecg_bitstream_packer #(.OUT_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ecg_valid          (ecg_valid),
        .ecg_ready          (ecg_ready),
        .encoded_ecg        (encoded_ecg),
        .sizeof_encoded_ecg (sizeof_encoded_ecg),
        .flush              (flush),
        .word_valid         (word_valid),
        .word_ready         (word_ready),
        .word_out           (word_out),
        .word_last          (word_last),
        .flush_done         (flush_done),
        .fill_level         (fill_level),
        .size_err           (size_err),
        .bits_total         (bits_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFailures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [49:0] ecg, input logic [6:0] size);
        ecg_valid          = valid;
        encoded_ecg        = ecg;
        sizeof_encoded_ecg = size;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        word_ready = 1'b0;
        applyStimulus(1'b0, 50'h0, 7'd0);
        #12;
        checkOutput("rst_ecg_ready",  64'(ecg_ready),  64'd1);
        checkOutput("rst_word_valid", 64'(word_valid), 64'd0);
        checkOutput("rst_word_out",   64'(word_out),   64'd0);
        checkOutput("rst_word_last",  64'(word_last),  64'd0);
        checkOutput("rst_flush_done", 64'(flush_done), 64'd0);
        checkOutput("rst_fill",       64'(fill_level), 64'd0);
        checkOutput("rst_size_err",   64'(size_err),   64'd0);
        checkOutput("rst_bits_total", 64'(bits_total), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic packing: 20 ones then 20 zeros
        applyStimulus(1'b1, {20'hFFFFF, 30'h0}, 7'd20);
        stepCycle();
        applyStimulus(1'b1, 50'h0, 7'd20);
        stepCycle();
        applyStimulus(1'b0, 50'h0, 7'd0);
        checkOutput("basic_word_valid", 64'(word_valid), 64'd1);
        checkOutput("basic_word_out",   64'(word_out),   64'hFFFFF000);
        checkOutput("basic_fill40",     64'(fill_level), 64'd40);
        word_ready = 1'b1;
        stepCycle();
        word_ready = 1'b0;
        checkOutput("basic_fill8",      64'(fill_level), 64'd8);
        checkOutput("basic_valid_low",  64'(word_valid), 64'd0);
`ifdef ECG_PACK_BITCNT_EN
        checkOutput("basic_bits_total", 64'(bits_total), 64'd40);
`else
        checkOutput("basic_bits_total", 64'(bits_total), 64'd0);
`endif

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_fill",  64'(fill_level), 64'd0);
        checkOutput("midrst_ready", 64'(ecg_ready),  64'd1);
        checkOutput("midrst_bits",  64'(bits_total), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush with 8-bit residue 0xA5
        applyStimulus(1'b1, {8'hA5, 42'h0}, 7'd8);
        stepCycle();
        applyStimulus(1'b0, 50'h0, 7'd0);
        checkOutput("flush_fill8", 64'(fill_level), 64'd8);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        checkOutput("pad_ecg_ready",  64'(ecg_ready),  64'd0);
        checkOutput("pad_word_valid", 64'(word_valid), 64'd0);
        word_ready = 1'b1;
        stepCycle();
        checkOutput("drain_valid",    64'(word_valid), 64'd1);
        checkOutput("drain_word",     64'(word_out),   64'hA5000000);
        checkOutput("drain_last",     64'(word_last),  64'd1);
        checkOutput("drain_fill",     64'(fill_level), 64'd32);
        checkOutput("drain_done_low", 64'(flush_done), 64'd0);
        stepCycle();
        checkOutput("flush_done_hi",  64'(flush_done), 64'd1);
        checkOutput("flush_fill0",    64'(fill_level), 64'd0);
        checkOutput("flush_valid0",   64'(word_valid), 64'd0);
        checkOutput("flush_ready",    64'(ecg_ready),  64'd1);
        stepCycle();
        checkOutput("flush_done_lo",  64'(flush_done), 64'd0);
        word_ready = 1'b0;

        // Illegal size 51, then legal ECGs pack normally
        applyStimulus(1'b1, {50{1'b1}}, 7'd51);
        stepCycle();
        checkOutput("err_size_err", 64'(size_err),   64'd1);
        checkOutput("err_fill",     64'(fill_level), 64'd0);
        applyStimulus(1'b1, {12'hABC, 38'h3FFFFFFFFF}, 7'd12);
        stepCycle();
        applyStimulus(1'b1, {20'h12345, 30'h0}, 7'd20);
        stepCycle();
        applyStimulus(1'b0, 50'h0, 7'd0);
        checkOutput("err_word",   64'(word_out),   64'hABC12345);
        checkOutput("err_fill32", 64'(fill_level), 64'd32);
        checkOutput("err_sticky", 64'(size_err),   64'd1);
        word_ready = 1'b1;
        stepCycle();
        word_ready = 1'b0;
        checkOutput("err_drained", 64'(fill_level), 64'd0);

        // Simultaneous push and pop at fill 40
        applyStimulus(1'b1, {20'hF0F0F, 30'h0}, 7'd20);
        stepCycle();
        applyStimulus(1'b1, {20'h33333, 30'h0}, 7'd20);
        stepCycle();
        applyStimulus(1'b0, 50'h0, 7'd0);
        checkOutput("sim_word_before", 64'(word_out),   64'hF0F0F333);
        checkOutput("sim_fill40",      64'(fill_level), 64'd40);
        word_ready = 1'b1;
        applyStimulus(1'b1, {30'h2AAAAAAA, 20'h0}, 7'd30);
        stepCycle();
        word_ready = 1'b0;
        applyStimulus(1'b0, 50'h0, 7'd0);
        checkOutput("sim_fill38",     64'(fill_level), 64'd38);
        checkOutput("sim_word_after", 64'(word_out),   64'h33AAAAAA);
`ifdef ECG_PACK_BITCNT_EN
        checkOutput("sim_bits_total", 64'(bits_total), 64'd110);
`else
        checkOutput("sim_bits_total", 64'(bits_total), 64'd0);
`endif

        // Backpressure: three size-50 ECGs with downstream stalled
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, {32'hDEADBEEF, 18'h0}, 7'd50);
        stepCycle();
        checkOutput("bp_fill50", 64'(fill_level), 64'd50);
        stepCycle();
        checkOutput("bp_fill100", 64'(fill_level), 64'd100);
        checkOutput("bp_ready0",  64'(ecg_ready),  64'd0);
        checkOutput("bp_word",    64'(word_out),   64'hDEADBEEF);
        stepCycle();
        checkOutput("bp_held_fill", 64'(fill_level), 64'd100);
        checkOutput("bp_held_word", 64'(word_out),   64'hDEADBEEF);
        applyStimulus(1'b0, 50'h0, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

endmodule
